// File: rtl/score_keeper.sv
// score_keeper: running score, session high score and life count for the
// asteroid game. Hit events are queued in a small FIFO and processed by a
// three-state FSM (IDLE -> ADD -> BONUS), one hit every three cycles.
module score_keeper #(
    parameter int unsigned SMALL_PTS   = 100,
    parameter int unsigned MED_PTS     = 50,
    parameter int unsigned LARGE_PTS   = 20,
    parameter int unsigned SAUCER_PTS  = 200,
    parameter int unsigned BONUS_STEP  = 10000,
    parameter int unsigned MAX_SCORE   = 999999,
    parameter int unsigned START_LIVES = 3,
    parameter int unsigned MAX_LIVES   = 9,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iNewGame,
    input  logic        iHitValid,
    input  logic [1:0]  iHitSize,
    output logic        oHitReady,
    input  logic        iLifeLost,
    output logic [19:0] oHexPoints,
    output logic [19:0] oHighScore,
    output logic [3:0]  oLives,
    output logic        oExtraLife,
    output logic        oGameOver
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [PTR_W:0] FULL_COUNT  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [19:0]    SCORE_MAX   = 20'(MAX_SCORE);
    localparam logic [19:0]    STEP        = 20'(BONUS_STEP);
    localparam logic [3:0]     LIVES_MAX   = 4'(MAX_LIVES);
    localparam logic [3:0]     LIVES_START = 4'(START_LIVES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        BONUS = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [1:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fifo_count;
    logic           fifo_full;
    logic           fifo_empty;

    logic [19:0] hit_pts;
    logic [19:0] threshold;
    logic [20:0] sum_ext;

    logic push;
    logic pop;
    logic award;
    logic life_dec;
    logic life_kill;

    // Point value for a hit size code.
    function automatic logic [19:0] pts_of(input logic [1:0] code);
        case (code)
            2'd0:    pts_of = 20'(SMALL_PTS);
            2'd1:    pts_of = 20'(MED_PTS);
            2'd2:    pts_of = 20'(LARGE_PTS);
            default: pts_of = 20'(SAUCER_PTS);
        endcase
    endfunction

    assign fifo_full  = (fifo_count == FULL_COUNT);
    assign fifo_empty = (fifo_count == '0);
    assign oHitReady  = !fifo_full && !oGameOver;

    // A bonus award happens in BONUS when the score has reached the threshold.
    assign award     = (state_q == BONUS) && (oHexPoints >= threshold);
    assign life_dec  = iLifeLost && !oGameOver && (oLives != '0);
    // Losing the last life only ends the game if no award offsets it.
    assign life_kill = life_dec && (oLives == 4'd1) && !award;

    assign push = iHitValid && oHitReady && !iNewGame && !life_kill;
    assign pop  = (state_q == IDLE) && !fifo_empty && !iNewGame && !life_kill;

    assign sum_ext = {1'b0, oHexPoints} + {1'b0, hit_pts};

    // Hit queue storage and pointers; flushed on reset, new game or game over.
    always_ff @(posedge iClk) begin
        if (iRst || iNewGame || life_kill) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= iHitSize;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Latch the point value of the entry being popped.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            hit_pts <= '0;
        end else if (pop) begin
            hit_pts <= pts_of(fifo_mem[rd_ptr]);
        end
    end

    // FSM state register; game over abandons any in-flight hit.
    always_ff @(posedge iClk) begin
        if (iRst || iNewGame || life_kill) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = ADD;
            ADD:     state_d = BONUS;
            BONUS:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Score, high score, bonus threshold, lives and game-over bookkeeping.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oHexPoints <= '0;
            oHighScore <= '0;
            oLives     <= LIVES_START;
            oExtraLife <= 1'b0;
            oGameOver  <= 1'b0;
            threshold  <= STEP;
        end else if (iNewGame) begin
            oHexPoints <= '0;
            oLives     <= LIVES_START;
            oExtraLife <= 1'b0;
            oGameOver  <= 1'b0;
            threshold  <= STEP;
        end else begin
            oExtraLife <= award;

            if ((state_q == ADD) && !life_kill) begin
                if (sum_ext > {1'b0, SCORE_MAX}) begin
                    oHexPoints <= SCORE_MAX;
                end else begin
                    oHexPoints <= sum_ext[19:0];
                end
            end

            if (award) begin
                threshold <= threshold + STEP;
            end

            if (((state_q == BONUS) && !life_kill) || oGameOver) begin
                if (oHexPoints > oHighScore) begin
                    oHighScore <= oHexPoints;
                end
            end

            // An award and a lost life in the same cycle cancel out.
            if (award && !life_dec) begin
                if (oLives < LIVES_MAX) begin
                    oLives <= oLives + 1'b1;
                end
            end else if (life_dec && !award) begin
                oLives <= oLives - 1'b1;
                if (oLives == 4'd1) begin
                    oGameOver <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: randomized and directed stimulus against a behavioural
// score model; expected score changes are queued and a monitor checks them.
module tb_score_keeper;

    logic        iClk;
    logic        iRst;
    logic        iNewGame;
    logic        iHitValid;
    logic [1:0]  iHitSize;
    logic        oHitReady;
    logic        iLifeLost;
    logic [19:0] oHexPoints;
    logic [19:0] oHighScore;
    logic [3:0]  oLives;
    logic        oExtraLife;
    logic        oGameOver;

    score_keeper #(
        .SMALL_PTS(100), .MED_PTS(50), .LARGE_PTS(20), .SAUCER_PTS(200),
        .BONUS_STEP(10000), .MAX_SCORE(999999), .START_LIVES(3),
        .MAX_LIVES(9), .FIFO_DEPTH(4)
    ) dut (
        .iClk(iClk), .iRst(iRst), .iNewGame(iNewGame),
        .iHitValid(iHitValid), .iHitSize(iHitSize), .oHitReady(oHitReady),
        .iLifeLost(iLifeLost), .oHexPoints(oHexPoints),
        .oHighScore(oHighScore), .oLives(oLives),
        .oExtraLife(oExtraLife), .oGameOver(oGameOver)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state.
    int  m_score, m_high, m_lives, m_thr, m_extra;
    bit  m_over;
    int  exp_q[$];

    // Monitor state.
    bit  mon_en = 0;
    int  last_score = 0;
    int  extra_seen = 0;

    // Free-running clock.
    initial iClk = 0;
    always #5 iClk = ~iClk;

    function automatic void check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endfunction

    function automatic int pts_of(input int code);
        case (code)
            0: return 100;
            1: return 50;
            2: return 20;
            default: return 200;
        endcase
    endfunction

    function automatic void model_hit(input int code);
        int ns;
        ns = m_score + pts_of(code);
        if (ns > 999999) ns = 999999;
        if (ns != m_score) exp_q.push_back(ns);
        m_score = ns;
        if (m_score >= m_thr) begin
            m_thr += 10000;
            m_extra++;
            if (m_lives < 9) m_lives++;
        end
        if (m_score > m_high) m_high = m_score;
    endfunction

    function automatic void model_life_lost();
        if (!m_over && m_lives > 0) begin
            if (m_lives > 1) m_lives--;
            else begin
                m_lives = 0;
                m_over = 1;
                if (m_score > m_high) m_high = m_score;
            end
        end
    endfunction

    function automatic void model_new_game();
        if (m_score != 0) exp_q.push_back(0);
        m_score = 0;
        m_lives = 3;
        m_thr = 10000;
        m_over = 0;
    endfunction

    // Monitor: every change of the displayed score must match the next expectation.
    always @(negedge iClk) begin
        if (mon_en) begin
            if (oExtraLife) extra_seen++;
            if (int'(oHexPoints) != last_score) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL score_unexpected got=%0d expected=no_change(%0d)", oHexPoints, last_score);
                end else begin
                    check("score_seq", oHexPoints, exp_q.pop_front());
                end
                last_score = int'(oHexPoints);
            end
        end
    end

    task automatic send(input int code, input bit apply);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        while (!acc && n < 50) begin
            iHitValid = 1;
            iHitSize = 2'(code);
            acc = oHitReady;
            @(negedge iClk);
            n++;
        end
        iHitValid = 0;
        if (!acc) check("ready_timeout", 0, 1);
        else if (apply) model_hit(code);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge iClk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        repeat (16) @(negedge iClk);
    endtask

    task automatic lose_life();
        iLifeLost = 1;
        @(negedge iClk);
        iLifeLost = 0;
        model_life_lost();
    endtask

    task automatic new_game();
        iNewGame = 1;
        @(negedge iClk);
        iNewGame = 0;
        model_new_game();
    endtask

    task automatic checkpoint(input string tag);
        check({tag, "_score"}, oHexPoints, m_score);
        check({tag, "_high"}, oHighScore, m_high);
        check({tag, "_lives"}, oLives, m_lives);
        check({tag, "_extra_count"}, extra_seen, m_extra);
        check({tag, "_gameover"}, oGameOver, m_over);
    endtask

    // Directed and randomized stimulus.
    initial begin
        bit ready_all;
        bit ready_low;
        bit acc;
        int accepted;
        int sc;

        iRst = 1; iNewGame = 0; iHitValid = 0; iHitSize = 0; iLifeLost = 0;
        m_score = 0; m_high = 0; m_lives = 3; m_thr = 10000; m_extra = 0; m_over = 0;
        repeat (3) @(negedge iClk);
        check("rst_score", oHexPoints, 0);
        check("rst_high", oHighScore, 0);
        check("rst_lives", oLives, 3);
        check("rst_extra", oExtraLife, 0);
        check("rst_gameover", oGameOver, 0);
        check("rst_ready", oHitReady, 1);
        iRst = 0;
        last_score = 0;
        mon_en = 1;

        // Back-to-back 2,1,0,3: 20, 70, 170, 370.
        ready_all = 1;
        foreach (sc_list[i]) begin
            if (!oHitReady) ready_all = 0;
            send(sc_list[i], 1);
        end
        check("b2b_ready", ready_all, 1);
        drain();
        check("b2b_final", oHexPoints, 370);
        checkpoint("b2b");

        // Build to 9950, then a small hit crosses 10000.
        new_game();
        repeat (49) send(3, 1);
        repeat (3) send(1, 1);
        drain();
        check("pre_bonus_score", oHexPoints, 9950);
        send(0, 1);
        drain();
        check("bonus_score", oHexPoints, 10050);
        check("bonus_lives", oLives, 4);
        checkpoint("bonus1");
        repeat (49) send(3, 1);
        send(0, 1);
        drain();
        check("pre_bonus2_lives", oLives, 4);
        send(0, 1);
        drain();
        check("bonus2_lives", oLives, 5);
        checkpoint("bonus2");

        // Backpressure: valid held for 8 cycles against a 4-deep queue.
        accepted = 0;
        ready_low = 0;
        for (int i = 0; i < 8; i++) begin
            sc = int'($urandom_range(0, 3));
            iHitValid = 1;
            iHitSize = 2'(sc);
            acc = oHitReady;
            if (!oHitReady) ready_low = 1;
            @(negedge iClk);
            if (acc) begin
                accepted++;
                model_hit(sc);
            end
        end
        iHitValid = 0;
        check("bp_ready_dropped", ready_low, 1);
        check("bp_accepted", accepted, 6);
        drain();
        checkpoint("backpressure");

        // Bonus award and life lost in the same cycle with two lives.
        new_game();
        lose_life();
        check("two_lives", oLives, 2);
        repeat (49) send(3, 1);
        repeat (3) send(1, 1);
        drain();
        send(0, 1);
        @(negedge iClk);
        @(negedge iClk);
        lose_life();
        drain();
        check("cancel_lives", oLives, 2);
        check("cancel_score", oHexPoints, 10050);
        checkpoint("cancel");

        // Game over with a hit in flight.
        new_game();
        lose_life();
        lose_life();
        send(3, 1);
        send(1, 1);
        drain();
        check("one_life", oLives, 1);
        send(0, 0);
        lose_life();
        check("go_lives", oLives, 0);
        check("go_flag", oGameOver, 1);
        check("go_ready", oHitReady, 0);
        repeat (2) @(negedge iClk);
        check("go_high", oHighScore, m_high);
        for (int i = 0; i < 5; i++) begin
            iHitValid = 1;
            iHitSize = 2'd3;
            @(negedge iClk);
            check("go_refuse", oHitReady, 0);
        end
        iHitValid = 0;
        drain();
        check("go_score_frozen", oHexPoints, 250);
        checkpoint("gameover");
        new_game();
        drain();
        check("ng_high_retained", oHighScore, m_high);
        checkpoint("newgame");

        // New game coinciding with a valid hit discards the hit.
        iNewGame = 1;
        iHitValid = 1;
        iHitSize = 2'd3;
        @(negedge iClk);
        iNewGame = 0;
        iHitValid = 0;
        model_new_game();
        drain();
        check("ng_hit_score", oHexPoints, 0);

        // Random hits with random gaps.
        for (int i = 0; i < 300; i++) begin
            send(int'($urandom_range(0, 3)), 1);
            repeat ($urandom_range(0, 3)) @(negedge iClk);
        end
        drain();
        checkpoint("random");

        // Saturation at 999999.
        new_game();
        repeat (4999) send(3, 1);
        send(0, 1);
        drain();
        check("sat_pre", oHexPoints, 999900);
        checkpoint("sat_pre");
        send(3, 1);
        drain();
        check("sat_score", oHexPoints, 999999);
        send(1, 1);
        drain();
        check("sat_hold", oHexPoints, 999999);
        checkpoint("sat");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    int sc_list[4] = '{2, 1, 0, 3};

endmodule
